// File: rtl/jt900h_useq.sv
// Microcode sequencer: opcode dispatch, slot stepping, conditional jump/call/ret and operand-width flags.
// Define JT900H_USTACK_CHK_EN to add sticky stack overflow/underflow flags (ovf/unf).
module jt900h_useq #(
  parameter int UAW = 14,
  parameter int OPW = 8,
  parameter int LOW = 4,
  parameter int DEPTH = 4,
  parameter logic [UAW-1:0] RST_UA = '0,
  parameter logic [UAW-1:0] INT_UA = 14'h0c70
)(
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  input  logic [OPW-1:0] op,
  input  logic           ni,
  input  logic           irq,
  input  logic           still,
  input  logic [7:0]     flags,
  input  logic [3:0]     cc_sel,
  input  logic           jmp_en,
  input  logic           jmp_cond,
  input  logic           call,
  input  logic           ret,
  input  logic [UAW-1:0] jmp_ua,
  input  logic           wset,
  input  logic [1:0]     wsel,
  input  logic           widen,
  output logic [UAW-1:0] uaddr,
  output logic           cc,
  output logic           bs,
  output logic           ws,
  output logic           qs,
  output logic [3:0]     sdepth
`ifdef JT900H_USTACK_CHK_EN
  ,
  output logic           ovf,
  output logic           unf
`endif
);

  logic           base;
  logic           taken;
  logic           full;
  logic           empty;
  logic           push_wr;
  logic [2:0]     wr_idx;
  logic [2:0]     rd_idx;
  logic [UAW-1:0] ret_addr;
  logic [UAW-1:0] step_addr;
  logic [UAW-1:0] dispatch;
  logic [UAW-1:0] top;
  logic [UAW-1:0] rd_vec [0:7];
  logic           unused_flags;

  // H and N are carried in the flag byte but no condition looks at them
  assign unused_flags = ^{flags[5], flags[4], flags[3], flags[1]};

  always_comb begin
    base = 1'b0;
    case (cc_sel[2:0])
      3'd0: base = 1'b0;
      3'd1: base = flags[7] ^ flags[2];
      3'd2: base = flags[6] | (flags[7] ^ flags[2]);
      3'd3: base = flags[6] | flags[0];
      3'd4: base = flags[2];
      3'd5: base = flags[7];
      3'd6: base = flags[6];
      3'd7: base = flags[0];
      default: base = 1'b0;
    endcase
  end

  // Selector 8 is "always", i.e. the inverse of selector 0
  assign cc = base ^ cc_sel[3];

  assign taken     = jmp_en & (~jmp_cond | cc);
  assign full      = sdepth == 4'(DEPTH);
  assign empty     = sdepth == 4'd0;
  assign ret_addr  = {uaddr[UAW-1:LOW], uaddr[LOW-1:0] + LOW'(1)};
  assign step_addr = ret_addr;
  assign dispatch  = UAW'({op, {LOW{1'b0}}});
  assign wr_idx    = full ? 3'(DEPTH-1) : sdepth[2:0];
  assign rd_idx    = empty ? 3'd0 : 3'(sdepth - 4'd1);
  assign top       = rd_vec[rd_idx];

`ifdef JT900H_USTACK_CHK_EN
  assign push_wr = ~ni & taken & call & ~full;
`else
  assign push_wr = ~ni & taken & call;
`endif

  // Stack entries carry no reset: only the occupancy count is flushed
  for (genvar gi = 0; gi < 8; gi++) begin : g_stack
    if (gi < DEPTH) begin : g_used
      logic [UAW-1:0] entry;
      always_ff @(posedge clk) begin
        if (cen && push_wr && wr_idx == 3'(gi))
          entry <= ret_addr;
      end
      assign rd_vec[gi] = entry;
    end else begin : g_unused
      assign rd_vec[gi] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uaddr  <= RST_UA;
      sdepth <= 4'd0;
`ifdef JT900H_USTACK_CHK_EN
      ovf    <= 1'b0;
      unf    <= 1'b0;
`endif
    end else if (cen) begin
      if (ni) begin
        uaddr  <= irq ? INT_UA : dispatch;
        sdepth <= 4'd0;
      end else if (taken) begin
        uaddr <= jmp_ua;
        if (call) begin
          if (!full)
            sdepth <= sdepth + 4'd1;
`ifdef JT900H_USTACK_CHK_EN
          else
            ovf <= 1'b1;
`endif
        end
      end else if (ret) begin
`ifdef JT900H_USTACK_CHK_EN
        if (empty) begin
          unf   <= 1'b1;
          uaddr <= RST_UA;
        end else begin
          uaddr  <= top;
          sdepth <= sdepth - 4'd1;
        end
`else
        uaddr <= top;
        if (!empty)
          sdepth <= sdepth - 4'd1;
`endif
      end else if (!still) begin
        uaddr <= step_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {qs, ws, bs} <= 3'b000;
    end else if (cen) begin
      if (ni) begin
        {qs, ws, bs} <= 3'b000;
      end else if (wset) begin
        case (wsel)
          2'd0:    {qs, ws, bs} <= 3'b001;
          2'd1:    {qs, ws, bs} <= 3'b010;
          2'd2:    {qs, ws, bs} <= 3'b100;
          default: {qs, ws, bs} <= 3'b000;
        endcase
      end else if (widen) begin
        {qs, ws, bs} <= {ws, bs, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_jt900h_useq.sv
// Directed self-checking bench for jt900h_useq (default parameters); covers JT900H_USTACK_CHK_EN when defined.
module tb_jt900h_useq;

  logic        rst, clk, cen, ni, irq, still;
  logic [7:0]  op, flags;
  logic [3:0]  cc_sel;
  logic        jmp_en, jmp_cond, call, ret, wset, widen;
  logic [1:0]  wsel;
  logic [13:0] jmp_ua;
  logic [13:0] uaddr;
  logic        cc, bs, ws, qs;
  logic [3:0]  sdepth;
`ifdef JT900H_USTACK_CHK_EN
  logic        ovf, unf;
`endif

  int compared = 0;
  int mismatched = 0;

  jt900h_useq dut (
    .rst(rst), .clk(clk), .cen(cen), .op(op), .ni(ni), .irq(irq), .still(still),
    .flags(flags), .cc_sel(cc_sel), .jmp_en(jmp_en), .jmp_cond(jmp_cond),
    .call(call), .ret(ret), .jmp_ua(jmp_ua), .wset(wset), .wsel(wsel),
    .widen(widen), .uaddr(uaddr), .cc(cc), .bs(bs), .ws(ws), .qs(qs),
    .sdepth(sdepth)
`ifdef JT900H_USTACK_CHK_EN
    , .ovf(ovf), .unf(unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ni = 0; irq = 0; still = 0; jmp_en = 0; jmp_cond = 0; call = 0; ret = 0;
    wset = 0; wsel = 2'd0; widen = 0; cc_sel = 4'd0;
  endtask

  task automatic jump(input logic [13:0] tgt, input logic c);
    clear();
    jmp_en = 1; jmp_ua = tgt; call = c;
    tick();
    clear();
  endtask

  logic [13:0] tgt [0:3];
  logic [13:0] rexp [0:3];
  logic [7:0]  pat [0:3];
  logic [15:0] mask [0:3];
  logic [15:0] m;

  initial begin
    tgt[0] = 14'h200; tgt[1] = 14'h300; tgt[2] = 14'h400; tgt[3] = 14'h600;
    rexp[0] = 14'h125; rexp[1] = 14'h201; rexp[2] = 14'h301; rexp[3] = 14'h401;
    pat[0] = 8'h00; pat[1] = 8'h41; pat[2] = 8'h80; pat[3] = 8'h96;
    mask[0] = 16'hFF00; mask[1] = 16'h33CC; mask[2] = 16'hD926; mask[3] = 16'hCF30;

    rst = 1; cen = 1; op = 8'h00; flags = 8'h00; jmp_ua = 14'h0;
    clear();
    #1;
    check("reset_uaddr", 32'(uaddr), 32'h0);
    check("reset_sdepth", 32'(sdepth), 32'h0);
    check("reset_width", 32'({qs, ws, bs}), 32'h0);
`ifdef JT900H_USTACK_CHK_EN
    check("reset_ovf_unf", 32'({ovf, unf}), 32'h0);
`endif
    @(posedge clk); @(posedge clk); #1 rst = 0;

    // dispatch and stepping
    ni = 1; op = 8'h3A;
    tick(); clear();
    check("dispatch", 32'(uaddr), 32'h03A0);
    tick(); check("step1", 32'(uaddr), 32'h03A1);
    tick(); check("step2", 32'(uaddr), 32'h03A2);
    tick(); check("step3", 32'(uaddr), 32'h03A3);

    // slot wrap, stall, clock enable
    jump(14'h03AF, 0);
    check("jump_3af", 32'(uaddr), 32'h03AF);
    still = 1; tick(); still = 0;
    check("still_hold", 32'(uaddr), 32'h03AF);
    tick(); check("slot_wrap", 32'(uaddr), 32'h03A0);
    cen = 0; tick(); cen = 1;
    check("cen_hold", 32'(uaddr), 32'h03A0);

    // simple call/return
    jump(14'h0123, 0);
    jump(14'h0500, 1);
    check("call_uaddr", 32'(uaddr), 32'h0500);
    check("call_sdepth", 32'(sdepth), 32'h1);
    ret = 1; still = 1; tick(); clear();
    check("ret_uaddr", 32'(uaddr), 32'h0124);
    check("ret_sdepth", 32'(sdepth), 32'h0);

    // nested calls unwind LIFO
    for (int i = 0; i < 4; i++) begin
      jump(tgt[i], 1);
      check("nest_call", 32'(uaddr), 32'(tgt[i]));
      check("nest_depth", 32'(sdepth), 32'(i + 1));
    end
    for (int i = 3; i >= 0; i--) begin
      ret = 1; tick(); clear();
      check("nest_ret", 32'(uaddr), 32'(rexp[i]));
      check("nest_ret_depth", 32'(sdepth), 32'(i));
    end

    // pop when empty
    ret = 1; tick(); clear();
`ifdef JT900H_USTACK_CHK_EN
    check("empty_pop_uaddr", 32'(uaddr), 32'h0);
    check("unf", 32'(unf), 32'h1);
`else
    check("empty_pop_uaddr", 32'(uaddr), 32'h0125);
`endif
    check("empty_pop_depth", 32'(sdepth), 32'h0);

    // push when full
    jump(14'h0700, 0);
    jump(14'h0710, 1); jump(14'h0720, 1); jump(14'h0730, 1); jump(14'h0740, 1);
    jump(14'h0750, 1);
    check("full_push_uaddr", 32'(uaddr), 32'h0750);
    check("full_push_depth", 32'(sdepth), 32'h4);
    ret = 1; tick(); clear();
`ifdef JT900H_USTACK_CHK_EN
    check("ovf", 32'(ovf), 32'h1);
    check("full_ret_uaddr", 32'(uaddr), 32'h0731);
`else
    check("full_ret_uaddr", 32'(uaddr), 32'h0741);
`endif
    check("full_ret_depth", 32'(sdepth), 32'h3);

    // conditional jump on Z
    ni = 1; op = 8'h10; tick(); clear();
    check("ni_flush", 32'(sdepth), 32'h0);
    jmp_en = 1; jmp_cond = 1; cc_sel = 4'd6; jmp_ua = 14'h0800; flags = 8'h00;
    tick();
    check("cond_not_taken", 32'(uaddr), 32'h0101);
    flags = 8'h40; tick(); clear();
    check("cond_taken", 32'(uaddr), 32'h0800);
    jmp_en = 1; jmp_cond = 1; call = 1; cc_sel = 4'd0; tick(); clear();
    check("nt_call_uaddr", 32'(uaddr), 32'h0801);
    check("nt_call_depth", 32'(sdepth), 32'h0);

    // condition sweep
    for (int p = 0; p < 4; p++) begin
      flags = pat[p];
      m = mask[p];
      for (int s = 0; s < 16; s++) begin
        cc_sel = 4'(s);
        #1;
        check("cc_sweep", 32'(cc), 32'(m[s]));
      end
    end
    clear();

    // interrupt and dispatch priority
    ni = 1; irq = 1; op = 8'h77; tick(); clear();
    check("irq_ua", 32'(uaddr), 32'h0c70);
    jump(14'h0900, 1);
    check("pre_prio_depth", 32'(sdepth), 32'h1);
    ni = 1; op = 8'h55; jmp_en = 1; jmp_ua = 14'h0222; call = 1; ret = 1;
    tick(); clear();
    check("prio_uaddr", 32'(uaddr), 32'h0550);
    check("prio_depth", 32'(sdepth), 32'h0);

    // width state
    wset = 1; wsel = 2'd0; tick(); clear();
    check("w_byte", 32'({qs, ws, bs}), 32'h1);
    widen = 1; tick(); check("w_word", 32'({qs, ws, bs}), 32'h2);
    tick(); check("w_quad", 32'({qs, ws, bs}), 32'h4);
    tick(); check("w_none", 32'({qs, ws, bs}), 32'h0);
    clear();
    wset = 1; wsel = 2'd1; widen = 1; tick(); clear();
    check("w_set_wins", 32'({qs, ws, bs}), 32'h2);
    wset = 1; wsel = 2'd3; tick(); clear();
    check("w_sel3", 32'({qs, ws, bs}), 32'h0);
    wset = 1; wsel = 2'd0; tick();
    ni = 1; op = 8'h12; wsel = 2'd2; tick(); clear();
    check("w_ni_clear", 32'({qs, ws, bs}), 32'h0);

    // asynchronous reset mid-routine
    jump(14'h0333, 1);
    check("pre_rst_depth", 32'(sdepth), 32'h1);
    @(posedge clk); #2 rst = 1; #1;
    check("async_rst_uaddr", 32'(uaddr), 32'h0);
    check("async_rst_depth", 32'(sdepth), 32'h0);
    @(posedge clk); #1 rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
